// File: rtl/riscv_cpu_pkg.sv
// riscv_cpu_pkg: shared CPU definitions.
//   DATA_WIDTH / ALU_OP_WIDTH  datapath and ALU opcode widths
//   ALU_*                      ALU opcodes
//   ALU_ARB_MAX_REQ            upper bound on requesters sharing the ALU
//   alu_arb_state_e            ALU arbiter FSM states
//   arb_idx_w()                requester index width (never below 1)
package riscv_cpu_pkg;

  localparam int unsigned DATA_WIDTH   = 32;
  localparam int unsigned ALU_OP_WIDTH = 4;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL  = 4'd2;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT  = 4'd3;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU = 4'd4;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = 4'd5;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL  = 4'd6;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA  = 4'd7;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = 4'd8;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = 4'd9;

  localparam int unsigned ALU_ARB_MAX_REQ = 8;

  typedef enum logic {ARB_IDLE, ARB_RESP} alu_arb_state_e;

  function automatic int unsigned arb_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_rr_picker.sv
// alu_rr_picker: combinational request picker for alu_arbiter.
//   valid       per-requester request valid
//   last_grant  index of the most recent grant (round-robin origin)
//   grant       one-hot grant (zero when nothing is valid)
//   idx         index of the granted requester
//   any_grant   some requester is granted
// Build option ALU_ARB_FIXED_PRIO_EN: lowest index wins and last_grant is ignored.
module alu_rr_picker
  import riscv_cpu_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W   = arb_idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any_grant
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;

  always_comb begin
    grant     = '0;
    idx       = '0;
    any_grant = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!any_grant && (|(valid & (NUM_REQ'(1) << i)))) begin
        any_grant = 1'b1;
        idx       = IDX_W'(i);
        grant     = NUM_REQ'(1) << i;
      end
    end
  end
`else
  int unsigned cand;

  // Search starts one past the last winner and wraps, so the previous
  // winner is considered last.
  always_comb begin
    grant     = '0;
    idx       = '0;
    any_grant = 1'b0;
    cand      = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(last_grant) + k) % NUM_REQ;
      if (!any_grant && (|(valid & (NUM_REQ'(1) << cand)))) begin
        any_grant = 1'b1;
        idx       = IDX_W'(cand);
        grant     = NUM_REQ'(1) << cand;
      end
    end
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between NUM_REQ requesters.
//   clk_i, rst_i (async, active-high), flush_i (drops any held result)
//   req_valid_i/req_ready_o, req_a_i/req_b_i/req_op_i  request channels
//   resp_valid_o/resp_ready_i, resp_data_o             response channels
//   alu_a_o/alu_b_o/alu_op_o -> ALU, alu_data_i <- ALU
//   busy_o                                             a result is held
// Build option ALU_ARB_FIXED_PRIO_EN: fixed lowest-index priority, no rr pointer.
module alu_arbiter
  import riscv_cpu_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W   = arb_idx_w(NUM_REQ)
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    flush_i,
  input  logic [NUM_REQ-1:0]                      req_valid_i,
  output logic [NUM_REQ-1:0]                      req_ready_o,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]      req_a_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]      req_b_i,
  input  logic [NUM_REQ-1:0][ALU_OP_WIDTH-1:0]    req_op_i,
  output logic [NUM_REQ-1:0]                      resp_valid_o,
  input  logic [NUM_REQ-1:0]                      resp_ready_i,
  output logic [DATA_WIDTH-1:0]                   resp_data_o,
  output logic [DATA_WIDTH-1:0]                   alu_a_o,
  output logic [DATA_WIDTH-1:0]                   alu_b_o,
  output logic [ALU_OP_WIDTH-1:0]                 alu_op_o,
  input  logic [DATA_WIDTH-1:0]                   alu_data_i,
  output logic                                    busy_o
);

  alu_arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]        owner_q, owner_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic [IDX_W-1:0]        pick_last;
  logic [NUM_REQ-1:0]      pick_grant;
  logic [IDX_W-1:0]        pick_idx;
  logic                    pick_any;
  logic                    resp_hs;
  logic                    arb_en;
  logic                    grant_hs;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign pick_last = '0;
`else
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  assign pick_last = last_grant_q;
`endif

  alu_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .valid      (req_valid_i),
    .last_grant (pick_last),
    .grant      (pick_grant),
    .idx        (pick_idx),
    .any_grant  (pick_any)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ARB_IDLE;
      owner_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      result_q <= result_d;
    end
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_grant_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  // A new grant is allowed while idle, or in the same cycle the owner takes
  // its result so back-to-back ops see no bubble. Flush and reset block it.
  always_comb begin
    resp_hs  = (state_q == ARB_RESP) && !flush_i && resp_ready_i[owner_q];
    arb_en   = !rst_i && !flush_i && ((state_q == ARB_IDLE) || resp_hs);
    grant_hs = arb_en && pick_any;

    req_ready_o = grant_hs ? pick_grant : '0;
    alu_a_o     = grant_hs ? req_a_i[pick_idx]  : '0;
    alu_b_o     = grant_hs ? req_b_i[pick_idx]  : '0;
    alu_op_o    = grant_hs ? req_op_i[pick_idx] : ALU_ADD;

    resp_valid_o = ((state_q == ARB_RESP) && !flush_i) ? (NUM_REQ'(1) << owner_q) : '0;
    resp_data_o  = (state_q == ARB_RESP) ? result_q : '0;
    busy_o       = (state_q == ARB_RESP);

    state_d  = state_q;
    owner_d  = owner_q;
    result_d = result_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif

    if (flush_i) begin
      state_d = ARB_IDLE;
    end else if (grant_hs) begin
      state_d  = ARB_RESP;
      owner_d  = pick_idx;
      result_d = alu_data_i;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant_d = pick_idx;
`endif
    end else if (resp_hs) begin
      state_d = ARB_IDLE;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and random checks of alu_arbiter against a
// transaction-level model (held result, owner, rr origin) and a local ALU.
module tb_alu_arbiter;
  import riscv_cpu_pkg::*;

  localparam int N = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  flush;
  logic [N-1:0]          req_valid;
  logic [N-1:0]          req_ready;
  logic [N-1:0][31:0]    req_a;
  logic [N-1:0][31:0]    req_b;
  logic [N-1:0][3:0]     req_op;
  logic [N-1:0]          resp_valid;
  logic [N-1:0]          resp_ready;
  logic [31:0]           resp_data;
  logic [31:0]           alu_a;
  logic [31:0]           alu_b;
  logic [3:0]            alu_op;
  logic [31:0]           alu_data;
  logic                  busy;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  bit          m_held;
  int          m_owner;
  logic [31:0] m_result;
  int          m_last;
  int          e_sel;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(N)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .req_op_i     (req_op),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_data_o  (resp_data),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_op_o     (alu_op),
    .alu_data_i   (alu_data),
    .busy_o       (busy)
  );

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'd0, a < b};
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $signed(a) >>> b[4:0];
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return a ^ ~b;
    endcase
  endfunction

  always_comb alu_data = alu_f(alu_op, alu_a, alu_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_held   = 0;
    m_owner  = 0;
    m_result = '0;
    m_last   = N - 1;
  endtask

  // Inputs were driven at the falling edge; let them settle, then compare
  // every output with what the model predicts for this cycle.
  task automatic settle_and_check();
    bit           hs;
    bit           arb;
    int           c;
    logic [N-1:0] er;
    logic [N-1:0] ev;
    #1;
    hs    = m_held && !flush && resp_ready[m_owner];
    arb   = !flush && (!m_held || hs);
    e_sel = -1;
    if (arb) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      for (int i = 0; i < N; i++)
        if (e_sel < 0 && req_valid[i]) e_sel = i;
`else
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (e_sel < 0 && req_valid[c]) e_sel = c;
      end
`endif
    end
    er = '0;
    if (e_sel >= 0) er[e_sel] = 1'b1;
    ev = '0;
    if (m_held && !flush) ev[m_owner] = 1'b1;
    chk("req_ready",  32'(req_ready),  32'(er));
    chk("alu_a",      alu_a,   (e_sel >= 0) ? req_a[e_sel] : 32'd0);
    chk("alu_b",      alu_b,   (e_sel >= 0) ? req_b[e_sel] : 32'd0);
    chk("alu_op",     32'(alu_op), 32'((e_sel >= 0) ? req_op[e_sel] : ALU_ADD));
    chk("resp_valid", 32'(resp_valid), 32'(ev));
    chk("resp_data",  resp_data, m_held ? m_result : 32'd0);
    chk("busy",       32'(busy), 32'(m_held));
  endtask

  task automatic advance();
    bit hs;
    @(posedge clk);
    hs = m_held && !flush && resp_ready[m_owner];
    if (flush) begin
      m_held = 0;
    end else if (e_sel >= 0) begin
      m_held   = 1;
      m_owner  = e_sel;
      m_result = alu_f(req_op[e_sel], req_a[e_sel], req_b[e_sel]);
      m_last   = e_sel;
    end else if (hs) begin
      m_held = 0;
    end
    @(negedge clk);
  endtask

  task automatic set_req(input int r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[r] = op;
    req_a[r]  = a;
    req_b[r]  = b;
  endtask

  bit          pend [N];
  logic [1:0]  g;

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    req_valid  = '1;
    resp_ready = '1;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    model_reset();

    // reset: everything quiet even with requests pending
    @(negedge clk);
    #1;
    chk("rst_req_ready",  32'(req_ready),  32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_resp_data",  resp_data,       32'd0);
    @(negedge clk);
    rst = 1'b0;

    // single request: 5 + 7
    req_valid = 2'b01;
    set_req(0, ALU_ADD, 32'd5, 32'd7);
    settle_and_check();
    advance();
    req_valid = 2'b00;
    settle_and_check();
    chk("single_data",  resp_data,        32'd12);
    chk("single_valid", 32'(resp_valid),  32'b01);
    advance();
    settle_and_check();
    chk("single_idle", 32'(busy), 32'd0);
    advance();

    // contention: both requesters always valid
    req_valid = 2'b11;
    set_req(0, ALU_SUB, 32'd10, 32'd3);
    set_req(1, ALU_XOR, 32'hF0, 32'h0F);
    for (int k = 0; k < 4; k++) begin
      settle_and_check();
`ifdef ALU_ARB_FIXED_PRIO_EN
      chk("cont_grant", 32'(req_ready), 32'b01);
      if (k > 0) chk("cont_data", resp_data, 32'd7);
`else
      // requester 0 won last, so requester 1 goes first here
      chk("cont_grant", 32'(req_ready), (k % 2 == 0) ? 32'b10 : 32'b01);
      if (k > 0) chk("cont_data", resp_data, (k % 2 == 1) ? 32'hFF : 32'd7);
`endif
      advance();
    end

    // backpressure: owner 1 stalls, requester 0's resp_ready is ignored
    req_valid = 2'b10;
    set_req(1, ALU_ADD, 32'd100, 32'd23);
    settle_and_check();
    chk("bp_grant1", 32'(req_ready), 32'b10);
    advance();
    req_valid  = 2'b01;
    resp_ready = 2'b01;
    for (int k = 0; k < 3; k++) begin
      settle_and_check();
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_data",  resp_data,      32'd123);
      advance();
    end
    resp_ready = 2'b10;
    settle_and_check();
    chk("bp_resume", 32'(req_ready), 32'b01);
    advance();

    // back-to-back: accept result and issue 1 << 4 in the same cycle
    resp_ready = 2'b11;
    set_req(0, ALU_SLL, 32'd1, 32'd4);
    settle_and_check();
    chk("b2b_busy",  32'(busy),      32'd1);
    chk("b2b_grant", 32'(req_ready), 32'b01);
    advance();
    req_valid = 2'b00;
    settle_and_check();
    chk("b2b_busy2", 32'(busy), 32'd1);
    chk("b2b_data",  resp_data, 32'd16);
    advance();

    // flush in RESP with requester 1 waiting
    req_valid = 2'b01;
    set_req(0, ALU_ADD, 32'd5, 32'd7);
    settle_and_check();
    advance();
    flush     = 1'b1;
    req_valid = 2'b10;
    set_req(1, ALU_ADD, 32'd1, 32'd2);
    settle_and_check();
    chk("flush_ready", 32'(req_ready),  32'd0);
    chk("flush_valid", 32'(resp_valid), 32'd0);
    advance();
    flush = 1'b0;
    settle_and_check();
    chk("flush_idle",  32'(busy),      32'd0);
    chk("flush_grant", 32'(req_ready), 32'b10);
    advance();

    // async reset while owner 1 holds its result
    req_valid  = 2'b11;
    resp_ready = 2'b00;
    settle_and_check();
    chk("pre_rst_data", resp_data, 32'd3);
    #1 rst = 1'b1;
    #1;
    chk("arst_resp_valid", 32'(resp_valid), 32'd0);
    chk("arst_busy",       32'(busy),       32'd0);
    chk("arst_ready",      32'(req_ready),  32'd0);
    chk("arst_data",       resp_data,       32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst        = 1'b0;
    resp_ready = 2'b11;
    settle_and_check();
    chk("post_rst_grant", 32'(req_ready), 32'b01);
    advance();
    req_valid = 2'b00;
    settle_and_check();
    advance();

    // random traffic obeying the hold-until-ready rule
    for (int r = 0; r < N; r++) pend[r] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int r = 0; r < N; r++) begin
        if (!pend[r] && $urandom_range(0, 3) != 0) begin
          pend[r] = 1;
          g = 2'($urandom_range(0, 3));
          set_req(r, ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 9)),
                  $urandom, (g == 0) ? 32'($urandom_range(0, 40)) : $urandom);
        end
        req_valid[r]  = pend[r];
        resp_ready[r] = ($urandom_range(0, 2) != 0);
      end
      flush = ($urandom_range(0, 19) == 0);
      settle_and_check();
      if (e_sel >= 0) pend[e_sel] = 0;
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
